// File: rtl/pong_pkg.sv
// Shared constants for the Pong game-phase controller: phase encodings, widths, modes, serve directions.
package pong_pkg;

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned MODE_W  = 2;
   localparam int unsigned STATE_W = 3;

   localparam logic [2:0] MENU      = 3'd0;
   localparam logic [2:0] SERVE     = 3'd1;
   localparam logic [2:0] PLAY      = 3'd2;
   localparam logic [2:0] HOLD      = 3'd3;
   localparam logic [2:0] GAME_OVER = 3'd4;
   localparam logic [2:0] PAUSED    = 3'd5;

   localparam logic [1:0] MODE_1P_AI = 2'b00;
   localparam logic [1:0] MODE_2P    = 2'b01;
   localparam logic [1:0] MODE_AI_AI = 2'b10;
   localparam logic [1:0] MODE_RSVD  = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // True for selectable game modes; the reserved code cannot start a match.
   function automatic logic mode_valid(input logic [MODE_W-1:0] m);
      case (m)
         MODE_1P_AI, MODE_2P, MODE_AI_AI: mode_valid = 1'b1;
         default:                         mode_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable 8-bit frame down-counter shared by the serve countdown and the point hold.
module frame_countdown
   import pong_pkg::*;
(
   input  logic             clk_0,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_tick,
   input  logic             i_freeze,
   output logic             o_zero_c
);

   logic [CNT_W-1:0] r_count;

   // Pulses on the tick that takes the count from 1 to 0; independent of i_load.
   assign o_zero_c = i_tick && !i_freeze && (r_count == CNT_W'(1));

   always_ff @(posedge clk_0) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && !i_freeze && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// Pong match phase controller: MENU -> SERVE -> PLAY -> HOLD -> GAME_OVER, owning scores and ball gating.
// Optional pause state enabled by defining MATCH_SEQUENCER_PAUSE_EN.
module match_sequencer
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE         = 9,
   parameter int unsigned SERVE_FRAMES      = 90,
   parameter int unsigned POINT_HOLD_FRAMES = 45,
   parameter int unsigned BLINK_FRAMES      = 8
) (
   input  logic               clk_0,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start_trigger,
   input  logic [MODE_W-1:0]  mode_choice,
   input  logic               point_p1,
   input  logic               point_p2,
   input  logic               pause_req,
   output logic [MODE_W-1:0]  active_mode,
   output logic               game_startup,
   output logic               ball_run,
   output logic               sq_shown,
   output logic               serve_dir,
   output logic               round_reset,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               game_over
);

   logic [STATE_W-1:0] r_state,       w_state_n;
   logic [MODE_W-1:0]  r_active_mode, w_mode_n;
   logic [SCORE_W-1:0] r_score_p1,    w_p1_n;
   logic [SCORE_W-1:0] r_score_p2,    w_p2_n;
   logic               r_serve_dir,   w_dir_n;
   logic               r_sq_shown,    w_shown_n;
   logic [CNT_W-1:0]   r_blink_cnt,   w_blink_n;
   logic               r_round_reset, w_rr_n;
   logic               r_ball_run;
   logic               r_game_over;
   logic               r_game_startup;

   logic               w_cnt_load;
   logic [CNT_W-1:0]   w_cnt_val;
   logic               w_cnt_zero;
   logic               w_freeze;
   logic               w_pause_go;
   logic [SCORE_W-1:0] w_p1_inc;
   logic [SCORE_W-1:0] w_p2_inc;
   logic [CNT_W-1:0]   w_blink_inc;

   assign w_p1_inc    = r_score_p1 + SCORE_W'(1);
   assign w_p2_inc    = r_score_p2 + SCORE_W'(1);
   assign w_blink_inc = r_blink_cnt + CNT_W'(1);

`ifdef MATCH_SEQUENCER_PAUSE_EN
   logic [STATE_W-1:0] r_ret_state;

   assign w_pause_go = pause_req && ((r_state == SERVE) || (r_state == PLAY) || (r_state == HOLD));

   // Remember which phase to resume once the pause is released.
   always_ff @(posedge clk_0) begin
      if (rst) begin
         r_ret_state <= MENU;
      end else if (w_pause_go) begin
         r_ret_state <= r_state;
      end
   end
`else
   logic w_unused_pause;
   assign w_unused_pause = pause_req;
   assign w_pause_go     = 1'b0;
`endif

   // Freeze on the entering cycle too, so a coinciding tick cannot expire the count.
   assign w_freeze = w_pause_go || (r_state == PAUSED);

   frame_countdown u_countdown (
      .clk_0      (clk_0),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_tick     (frame_tick),
      .i_freeze   (w_freeze),
      .o_zero_c   (w_cnt_zero)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_n  = r_state;
      w_mode_n   = r_active_mode;
      w_p1_n     = r_score_p1;
      w_p2_n     = r_score_p2;
      w_dir_n    = r_serve_dir;
      w_shown_n  = r_sq_shown;
      w_blink_n  = r_blink_cnt;
      w_rr_n     = 1'b0;
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;

      if (w_pause_go) begin
         w_state_n = PAUSED;
      end else begin
         case (r_state)
            MENU: begin
               if (start_trigger && mode_valid(mode_choice)) begin
                  w_state_n  = SERVE;
                  w_mode_n   = mode_choice;
                  w_p1_n     = '0;
                  w_p2_n     = '0;
                  w_dir_n    = DIR_LEFT;
                  w_rr_n     = 1'b1;
                  w_cnt_load = 1'b1;
                  w_cnt_val  = CNT_W'(SERVE_FRAMES);
                  w_shown_n  = 1'b1;
                  w_blink_n  = '0;
               end
            end
            SERVE: begin
               if (w_cnt_zero) begin
                  w_state_n = PLAY;
                  w_shown_n = 1'b1;
               end else if (frame_tick) begin
                  if (w_blink_inc == CNT_W'(BLINK_FRAMES)) begin
                     w_blink_n = '0;
                     w_shown_n = !r_sq_shown;
                  end else begin
                     w_blink_n = w_blink_inc;
                  end
               end
            end
            PLAY: begin
               // P1 wins a tie of simultaneous point pulses.
               if (point_p1 || point_p2) begin
                  if (point_p1) begin
                     w_p1_n  = w_p1_inc;
                     w_dir_n = DIR_RIGHT;
                  end else begin
                     w_p2_n  = w_p2_inc;
                     w_dir_n = DIR_LEFT;
                  end
                  w_shown_n = 1'b0;
                  if ((point_p1 && (w_p1_inc == SCORE_W'(WIN_SCORE))) ||
                      (!point_p1 && (w_p2_inc == SCORE_W'(WIN_SCORE)))) begin
                     w_state_n = GAME_OVER;
                  end else begin
                     w_state_n  = HOLD;
                     w_cnt_load = 1'b1;
                     w_cnt_val  = CNT_W'(POINT_HOLD_FRAMES);
                  end
               end
            end
            HOLD: begin
               if (w_cnt_zero) begin
                  w_state_n  = SERVE;
                  w_rr_n     = 1'b1;
                  w_cnt_load = 1'b1;
                  w_cnt_val  = CNT_W'(SERVE_FRAMES);
                  w_shown_n  = 1'b1;
                  w_blink_n  = '0;
               end
            end
            GAME_OVER: begin
               w_shown_n = 1'b0;
               if (start_trigger) begin
                  w_state_n = MENU;
               end
            end
`ifdef MATCH_SEQUENCER_PAUSE_EN
            PAUSED: begin
               if (pause_req) begin
                  w_state_n = r_ret_state;
                  if (r_ret_state == PLAY) begin
                     w_shown_n = 1'b1;
                  end
               end
            end
`endif
            default: begin
               w_state_n = MENU;
               w_shown_n = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_0) begin
      if (rst) begin
         r_state        <= MENU;
         r_active_mode  <= MODE_1P_AI;
         r_score_p1     <= '0;
         r_score_p2     <= '0;
         r_serve_dir    <= DIR_LEFT;
         r_sq_shown     <= 1'b0;
         r_blink_cnt    <= '0;
         r_round_reset  <= 1'b0;
         r_ball_run     <= 1'b0;
         r_game_over    <= 1'b0;
         r_game_startup <= 1'b1;
      end else begin
         r_state        <= w_state_n;
         r_active_mode  <= w_mode_n;
         r_score_p1     <= w_p1_n;
         r_score_p2     <= w_p2_n;
         r_serve_dir    <= w_dir_n;
         r_sq_shown     <= w_shown_n;
         r_blink_cnt    <= w_blink_n;
         r_round_reset  <= w_rr_n;
         r_ball_run     <= (w_state_n == PLAY);
         r_game_over    <= (w_state_n == GAME_OVER);
         r_game_startup <= (w_state_n == MENU);
      end
   end

   assign active_mode  = r_active_mode;
   assign game_startup = r_game_startup;
   assign ball_run     = r_ball_run;
   assign sq_shown     = r_sq_shown;
   assign serve_dir    = r_serve_dir;
   assign round_reset  = r_round_reset;
   assign score_p1     = r_score_p1;
   assign score_p2     = r_score_p2;
   assign game_over    = r_game_over;

endmodule
